// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: datapath widths and opcode encodings.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the decode/execute stage and the ALU.
// The overflow signal exists only when ALU_OVERFLOW_EN is defined.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0]  srcA;
  logic [DATA_W-1:0]  srcB;
  logic [2:0]         ALUop;
  logic [SHAMT_W-1:0] s;
  logic [DATA_W-1:0]  ALUout;
  logic               zero;
`ifdef ALU_OVERFLOW_EN
  logic               overflow;
`endif

  modport master (
    output srcA, srcB, ALUop, s,
`ifdef ALU_OVERFLOW_EN
    input  overflow,
`endif
    input  ALUout, zero
  );

  modport slave (
    input  srcA, srcB, ALUop, s,
`ifdef ALU_OVERFLOW_EN
    output overflow,
`endif
    output ALUout, zero
  );

endinterface

// File: rtl/alu_shifter.sv
// Combinational 5-stage barrel shifter: logical left (zero fill) or arithmetic right (sign fill).
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  b,
  input  logic [SHAMT_W-1:0] s,
  input  logic               left,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W-1:0] cur;

  // Stage i shifts by 2**i when bit i of the shift amount is set.
  always_comb begin
    cur = b;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (s[i]) begin
        if (left) begin
          cur = cur << (2 ** i);
        end else begin
          cur = $unsigned($signed(cur) >>> (2 ** i));
        end
      end
    end
    result = cur;
  end

endmodule

// File: rtl/alu_unit.sv
// Registered 32-bit ALU for the execute stage; one-cycle latency, result plus zero flag.
// Define ALU_OVERFLOW_EN to add the registered signed-overflow flag.
module alu_unit
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);

  logic [DATA_W-1:0] sum, diff, shift_res;
  logic [DATA_W-1:0] result_d, result_q;
  logic              zero_q;

  assign sum  = bus.srcA + bus.srcB;
  assign diff = bus.srcA - bus.srcB;

  alu_shifter u_shifter (
    .b      (bus.srcB),
    .s      (bus.s),
    .left   (bus.ALUop == ALU_SLL),
    .result (shift_res)
  );

  always_comb begin
    result_d = '0;
    case (bus.ALUop)
      ALU_ADD: result_d = sum;
      ALU_SUB: result_d = diff;
      ALU_AND: result_d = bus.srcA & bus.srcB;
      ALU_OR:  result_d = bus.srcA | bus.srcB;
      ALU_XOR: result_d = bus.srcA ^ bus.srcB;
      ALU_SLT: result_d = {{(DATA_W-1){1'b0}}, ($signed(bus.srcA) < $signed(bus.srcB))};
      ALU_SLL: result_d = shift_res;
      ALU_SRA: result_d = shift_res;
      default: result_d = '0;
    endcase
  end

  // zero comes from the same next-state value as the result so the two never disagree.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= (result_d == '0);
    end
  end

  assign bus.ALUout = result_q;
  assign bus.zero   = zero_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_d, ovf_q;
  logic sa, sb;

  assign sa = bus.srcA[DATA_W-1];
  assign sb = bus.srcB[DATA_W-1];

  always_comb begin
    ovf_d = 1'b0;
    case (bus.ALUop)
      ALU_ADD: ovf_d = (sa == sb) && (sum[DATA_W-1] != sa);
      ALU_SUB: ovf_d = (sa != sb) && (diff[DATA_W-1] != sa);
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit with hand-computed expected values.
module tb_alu_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_if bus ();

  alu_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] sh);
    bus.srcA  = a;
    bus.srcB  = b;
    bus.ALUop = op;
    bus.s     = sh;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef ALU_OVERFLOW_EN
    check(tag, {31'b0, bus.overflow}, {31'b0, exp});
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held two cycles with arbitrary inputs
    reset = 1'b1;
    drive(32'h1234_5678, 32'h0000_0001, 3'b000, 5'd7);
    step();
    check("rst1_out", bus.ALUout, 32'h0);
    check("rst1_zero", {31'b0, bus.zero}, 32'h1);
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 5'd3);
    step();
    check("rst2_out", bus.ALUout, 32'h0);
    check("rst2_zero", {31'b0, bus.zero}, 32'h1);
    check_ovf("rst2_ovf", 1'b0);

    reset = 1'b0;
    drive(32'd200, 32'd200, 3'b110, 5'd3);
    step();
    check("sll_200", bus.ALUout, 32'd1600);
    check("sll_200_zero", {31'b0, bus.zero}, 32'h0);

    drive(32'd200, 32'h8000_0001, 3'b110, 5'd1);
    step();
    check("sll_msb_drop", bus.ALUout, 32'h0000_0002);

    drive(32'd200, 32'd200, 3'b001, 5'd9);
    step();
    check("sub_eq", bus.ALUout, 32'h0);
    check("sub_eq_zero", {31'b0, bus.zero}, 32'h1);

    drive(32'd200, 32'd200, 3'b000, 5'd0);
    step();
    check("add_400", bus.ALUout, 32'd400);
    check("add_400_zero", {31'b0, bus.zero}, 32'h0);
    check_ovf("add_400_ovf", 1'b0);

    // Input change between edges must not disturb outputs
    #2;
    drive(32'd1, 32'd2, 3'b001, 5'd0);
    #1;
    check("stable_out", bus.ALUout, 32'd400);
    check("stable_zero", {31'b0, bus.zero}, 32'h0);

    drive(32'hFFFF_FFFF, 32'd1, 3'b101, 5'd4);
    step();
    check("slt_neg_lt", bus.ALUout, 32'h1);

    drive(32'd1, 32'hFFFF_FFFF, 3'b101, 5'd4);
    step();
    check("slt_swap", bus.ALUout, 32'h0);
    check("slt_swap_zero", {31'b0, bus.zero}, 32'h1);

    drive(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, 5'd0);
    step();
    check("slt_minint", bus.ALUout, 32'h1);

    drive(32'h0, 32'h8000_0000, 3'b111, 5'd31);
    step();
    check("sra_31", bus.ALUout, 32'hFFFF_FFFF);

    drive(32'hFFFF_FFFF, 32'h4000_0000, 3'b111, 5'd4);
    step();
    check("sra_pos", bus.ALUout, 32'h0400_0000);

    drive(32'h0, 32'h9000_0000, 3'b111, 5'd5);
    step();
    check("sra_neg5", bus.ALUout, 32'hFC80_0000);

    drive(32'h0, 32'hDEAD_BEEF, 3'b111, 5'd0);
    step();
    check("sra_s0", bus.ALUout, 32'hDEAD_BEEF);

    drive(32'h0, 32'hDEAD_BEEF, 3'b110, 5'd0);
    step();
    check("sll_s0", bus.ALUout, 32'hDEAD_BEEF);

    drive(32'h1, 32'h1, 3'b110, 5'd31);
    step();
    check("sll_31", bus.ALUout, 32'h8000_0000);

    drive(32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'b010, 5'd3);
    step();
    check("and", bus.ALUout, 32'h00F0_00F0);

    drive(32'h1234_0000, 32'h0000_5678, 3'b011, 5'd0);
    step();
    check("or", bus.ALUout, 32'h1234_5678);

    drive(32'hA5A5_5A5A, 32'hA5A5_5A5A, 3'b100, 5'd0);
    step();
    check("xor_eq", bus.ALUout, 32'h0);
    check("xor_eq_zero", {31'b0, bus.zero}, 32'h1);

    drive(32'hFF00_FF00, 32'h0F0F_0F0F, 3'b100, 5'd0);
    step();
    check("xor", bus.ALUout, 32'hF00F_F00F);

    drive(32'h0, 32'h1, 3'b001, 5'd0);
    step();
    check("sub_wrap", bus.ALUout, 32'hFFFF_FFFF);
    check_ovf("sub_wrap_ovf", 1'b0);

    drive(32'hFFFF_FFFF, 32'h1, 3'b000, 5'd0);
    step();
    check("add_wrap", bus.ALUout, 32'h0);
    check("add_wrap_zero", {31'b0, bus.zero}, 32'h1);
    check_ovf("add_wrap_ovf", 1'b0);

    drive(32'h7FFF_FFFF, 32'h1, 3'b000, 5'd0);
    step();
    check("add_ovf_out", bus.ALUout, 32'h8000_0000);
    check_ovf("add_ovf", 1'b1);

    drive(32'h8000_0000, 32'h1, 3'b001, 5'd0);
    step();
    check("sub_ovf_out", bus.ALUout, 32'h7FFF_FFFF);
    check_ovf("sub_ovf", 1'b1);

    // Reset mid-stream discards the operation sampled on the reset edge
    reset = 1'b1;
    drive(32'h7FFF_FFFF, 32'h1, 3'b000, 5'd0);
    step();
    check("rst_mid_out", bus.ALUout, 32'h0);
    check("rst_mid_zero", {31'b0, bus.zero}, 32'h1);
    check_ovf("rst_mid_ovf", 1'b0);

    reset = 1'b0;
    drive(32'd5, 32'd7, 3'b000, 5'd0);
    step();
    check("post_rst_add", bus.ALUout, 32'd12);
    check("post_rst_zero", {31'b0, bus.zero}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
